// File: rtl/matmul_job_scheduler.sv
// Queues matmul jobs and issues them one at a time to the systolic wrapper via start/done.
// Optional build macro SCHED_PERF_EN adds last-job cycle count and completed-job counters.
module matmul_job_scheduler #(
  parameter int unsigned ADDRESS_WIDTH  = 13,
  parameter int unsigned QUEUE_DEPTH    = 4,
  parameter int unsigned TAG_WIDTH      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_cmd_valid,
  output logic                             o_cmd_ready,
  input  logic [TAG_WIDTH-1:0]             i_cmd_tag,
  input  logic [ADDRESS_WIDTH-1:0]         i_cmd_addr_w,
  input  logic [ADDRESS_WIDTH-1:0]         i_cmd_addr_x,
  input  logic [ADDRESS_WIDTH-1:0]         i_cmd_addr_out,
  output logic                             o_mm_start,
  output logic [ADDRESS_WIDTH-1:0]         o_mm_base_addr_w,
  output logic [ADDRESS_WIDTH-1:0]         o_mm_base_addr_x,
  output logic [ADDRESS_WIDTH-1:0]         o_mm_base_addr_out,
  input  logic                             i_mm_done,
  output logic                             o_cpl_valid,
  input  logic                             i_cpl_ready,
  output logic [TAG_WIDTH-1:0]             o_cpl_tag,
  output logic                             o_cpl_err,
  output logic                             o_busy,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0] o_queue_count
`ifdef SCHED_PERF_EN
  ,
  output logic [31:0]                      o_perf_last_cycles,
  output logic [31:0]                      o_perf_jobs
`endif
);

  localparam int unsigned PtrW   = $clog2(QUEUE_DEPTH);
  localparam int unsigned CntW   = $clog2(QUEUE_DEPTH + 1);
  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned EntryW = TAG_WIDTH + 3 * ADDRESS_WIDTH;
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCpl,
    StHalt
  } state_e;

  state_e r_state;
  state_e w_state_next;

  logic [EntryW-1:0]        r_fifo [QUEUE_DEPTH];
  logic [PtrW-1:0]          r_wr_ptr;
  logic [PtrW-1:0]          r_rd_ptr;
  logic [CntW-1:0]          r_count;
  logic                     w_full;
  logic                     w_push;
  logic                     w_pop;
  logic [EntryW-1:0]        w_head;

  logic                     w_done_ok;
  logic                     w_timeout;
  logic                     w_cpl_hs;
  logic [TimerW-1:0]        r_timer;
  logic [TAG_WIDTH-1:0]     r_cur_tag;
  logic                     r_mm_start;
  logic [ADDRESS_WIDTH-1:0] r_addr_w;
  logic [ADDRESS_WIDTH-1:0] r_addr_x;
  logic [ADDRESS_WIDTH-1:0] r_addr_out;
  logic                     r_cpl_valid;
  logic [TAG_WIDTH-1:0]     r_cpl_tag;
  logic                     r_cpl_err;

  // Full blocks new commands even when a pop happens in the same cycle.
  assign w_full      = (r_count == CntW'(QUEUE_DEPTH));
  assign o_cmd_ready = !w_full && !i_rst;
  assign w_push      = i_cmd_valid && o_cmd_ready;
  assign w_head      = r_fifo[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= {i_cmd_tag, i_cmd_addr_w, i_cmd_addr_x, i_cmd_addr_out};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_push && w_pop) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_done_ok    = 1'b0;
    w_timeout    = 1'b0;
    w_cpl_hs     = 1'b0;
    case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_state_next = StIssue;
        end
      end
      StIssue: begin
        w_pop        = 1'b1;
        w_state_next = StWait;
      end
      StWait: begin
        // A done arriving on the expiry cycle still counts as success.
        if (i_mm_done) begin
          w_done_ok    = 1'b1;
          w_state_next = StCpl;
        end else if (r_timer == TimerLast) begin
          w_timeout    = 1'b1;
          w_state_next = StCpl;
        end
      end
      StCpl: begin
        if (i_cpl_ready) begin
          w_cpl_hs     = 1'b1;
          w_state_next = r_cpl_err ? StHalt : StIdle;
        end
      end
      StHalt: begin
        w_state_next = StHalt;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mm_start  <= 1'b0;
      r_addr_w    <= '0;
      r_addr_x    <= '0;
      r_addr_out  <= '0;
      r_cur_tag   <= '0;
      r_timer     <= '0;
      r_cpl_valid <= 1'b0;
      r_cpl_tag   <= '0;
      r_cpl_err   <= 1'b0;
    end else begin
      r_mm_start <= w_pop;
      if (w_pop) begin
        {r_cur_tag, r_addr_w, r_addr_x, r_addr_out} <= w_head;
        r_timer <= '0;
      end else if (r_state == StWait && w_state_next == StWait) begin
        r_timer <= r_timer + TimerW'(1);
      end
      if (w_done_ok || w_timeout) begin
        r_cpl_valid <= 1'b1;
        r_cpl_tag   <= r_cur_tag;
        r_cpl_err   <= w_timeout;
      end else if (w_cpl_hs) begin
        r_cpl_valid <= 1'b0;
      end
    end
  end

  assign o_mm_start         = r_mm_start;
  assign o_mm_base_addr_w   = r_addr_w;
  assign o_mm_base_addr_x   = r_addr_x;
  assign o_mm_base_addr_out = r_addr_out;
  assign o_cpl_valid        = r_cpl_valid;
  assign o_cpl_tag          = r_cpl_tag;
  assign o_cpl_err          = r_cpl_err;
  assign o_busy             = (r_state != StIdle) || (r_count != '0);
  assign o_queue_count      = r_count;

`ifdef SCHED_PERF_EN
  logic [31:0] r_perf_last_cycles;
  logic [31:0] r_perf_jobs;

  // The timer holds the cycles since issue when done is sampled.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_last_cycles <= '0;
      r_perf_jobs        <= '0;
    end else begin
      if (w_done_ok) begin
        r_perf_last_cycles <= 32'(r_timer);
      end
      if (w_cpl_hs) begin
        r_perf_jobs <= r_perf_jobs + 32'd1;
      end
    end
  end

  assign o_perf_last_cycles = r_perf_last_cycles;
  assign o_perf_jobs        = r_perf_jobs;
`endif

`ifndef SYNTHESIS
  a_start_single: assert property (@(posedge i_clk) disable iff (i_rst)
    r_mm_start |=> !r_mm_start);
  a_pop_nonempty: assert property (@(posedge i_clk) disable iff (i_rst)
    w_pop |-> (r_count != '0));
  a_cpl_stable: assert property (@(posedge i_clk) disable iff (i_rst)
    (r_cpl_valid && !i_cpl_ready) |=>
      (r_cpl_valid && $stable(r_cpl_tag) && $stable(r_cpl_err)));
`endif

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Directed bench for matmul_job_scheduler: default-timeout DUT plus a TIMEOUT_CYCLES=16 copy.
// Issue addresses and completions are checked against a scoreboard filled at command accept.
module tb_matmul_job_scheduler;
  localparam int unsigned AW = 13;
  localparam int unsigned TW = 4;
  localparam int unsigned CW = 3;

  logic          clk       = 1'b0;
  logic          rst       = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [TW-1:0] cmd_tag   = '0;
  logic [AW-1:0] cmd_w     = '0;
  logic [AW-1:0] cmd_x     = '0;
  logic [AW-1:0] cmd_o     = '0;
  logic          mm_done   = 1'b0;
  logic          cpl_ready = 1'b0;

  logic a_cmd_ready, a_mm_start, a_cpl_valid, a_cpl_err, a_busy;
  logic t_cmd_ready, t_mm_start, t_cpl_valid, t_cpl_err, t_busy;
  logic [AW-1:0] a_mm_w, a_mm_x, a_mm_o, t_mm_w, t_mm_x, t_mm_o;
  logic [TW-1:0] a_cpl_tag, t_cpl_tag;
  logic [CW-1:0] a_queue_count, t_queue_count;
`ifdef SCHED_PERF_EN
  logic [31:0] a_perf_last, a_perf_jobs, t_perf_last, t_perf_jobs;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  logic [3*AW-1:0] issue_q [$];
  logic [TW:0]     cpl_q   [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  matmul_job_scheduler dut_a (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(a_cmd_ready),
    .i_cmd_tag(cmd_tag), .i_cmd_addr_w(cmd_w), .i_cmd_addr_x(cmd_x), .i_cmd_addr_out(cmd_o),
    .o_mm_start(a_mm_start), .o_mm_base_addr_w(a_mm_w), .o_mm_base_addr_x(a_mm_x),
    .o_mm_base_addr_out(a_mm_o), .i_mm_done(mm_done), .o_cpl_valid(a_cpl_valid),
    .i_cpl_ready(cpl_ready), .o_cpl_tag(a_cpl_tag), .o_cpl_err(a_cpl_err), .o_busy(a_busy),
    .o_queue_count(a_queue_count)
`ifdef SCHED_PERF_EN
    , .o_perf_last_cycles(a_perf_last), .o_perf_jobs(a_perf_jobs)
`endif
  );

  matmul_job_scheduler #(.TIMEOUT_CYCLES(16)) dut_t (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(cmd_valid), .o_cmd_ready(t_cmd_ready),
    .i_cmd_tag(cmd_tag), .i_cmd_addr_w(cmd_w), .i_cmd_addr_x(cmd_x), .i_cmd_addr_out(cmd_o),
    .o_mm_start(t_mm_start), .o_mm_base_addr_w(t_mm_w), .o_mm_base_addr_x(t_mm_x),
    .o_mm_base_addr_out(t_mm_o), .i_mm_done(mm_done), .o_cpl_valid(t_cpl_valid),
    .i_cpl_ready(cpl_ready), .o_cpl_tag(t_cpl_tag), .o_cpl_err(t_cpl_err), .o_busy(t_busy),
    .o_queue_count(t_queue_count)
`ifdef SCHED_PERF_EN
    , .o_perf_last_cycles(t_perf_last), .o_perf_jobs(t_perf_jobs)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic pulse_done();
    mm_done = 1'b1;
    tick(1);
    mm_done = 1'b0;
  endtask

  task automatic push_job(input logic [TW-1:0] tag, input logic [AW-1:0] w, x, o,
                          input int tries, output bit acc, output int k);
    acc = 1'b0;
    k   = 0;
    cmd_valid = 1'b1;
    cmd_tag   = tag;
    cmd_w     = w;
    cmd_x     = x;
    cmd_o     = o;
    for (int i = 0; i < tries && !acc; i++) begin
      @(negedge clk);
      if (a_cmd_ready === 1'b1) begin
        acc = 1'b1;
        if (mon_en) begin
          issue_q.push_back({w, x, o});
          cpl_q.push_back({tag, 1'b0});
        end
      end
      tick(1);
      if (acc) k = cyc;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_start(input bit use_t, output int s);
    bit found = 1'b0;
    s = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if ((use_t ? t_mm_start : a_mm_start) === 1'b1) begin
        found = 1'b1;
        s     = cyc;
      end
    end
    check("start_seen", 64'(found), 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (cpl_q.size() != 0 || a_busy !== 1'b0); i++) begin
      @(negedge clk);
    end
    check("drain_cpl_q", 64'(cpl_q.size()), 64'd0);
    check("drain_issue_q", 64'(issue_q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (mon_en && a_mm_start === 1'b1) begin
      check("issue_pending", 64'(issue_q.size() != 0), 64'd1);
      if (issue_q.size() != 0) begin
        check("issue_addr", 64'({a_mm_w, a_mm_x, a_mm_o}), 64'(issue_q.pop_front()));
      end
    end
    if (mon_en && a_cpl_valid === 1'b1 && cpl_ready === 1'b1) begin
      check("cpl_pending", 64'(cpl_q.size() != 0), 64'd1);
      if (cpl_q.size() != 0) begin
        check("cpl_tag_err", 64'({a_cpl_tag, a_cpl_err}), 64'(cpl_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    bit found;
    int k;
    int s;
    int p;
    int nstart;

    // Reset held for three cycles.
    tick(3);
    @(negedge clk);
    check("rst_ready", 64'(a_cmd_ready), 64'd0);
    check("rst_outs_a", 64'({a_mm_start, a_cpl_valid, a_cpl_tag, a_cpl_err, a_busy,
                             a_queue_count}), 64'd0);
    check("rst_addr_a", 64'({a_mm_w, a_mm_x, a_mm_o}), 64'd0);
    check("rst_outs_t", 64'({t_cmd_ready, t_mm_start, t_cpl_valid, t_busy, t_queue_count}),
          64'd0);
`ifdef SCHED_PERF_EN
    check("rst_perf", 64'({a_perf_last, a_perf_jobs}), 64'd0);
`endif
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", 64'(a_cmd_ready), 64'd1);
    tick(1);

    // Single job, done 20 cycles after start.
    mon_en    = 1'b1;
    cpl_ready = 1'b1;
    push_job(4'd5, 13'h000, 13'h040, 13'h080, 5, acc, k);
    check("single_accept", 64'(acc), 64'd1);
    wait_start(1'b0, s);
    check("start_latency", 64'(s), 64'(k + 2));
    @(negedge clk);
    check("start_pulse", 64'(a_mm_start), 64'd0);
    repeat (19) @(posedge clk);
    #1;
    pulse_done();
    @(negedge clk);
    check("cpl_latency", 64'({a_cpl_valid, a_cpl_tag, a_cpl_err}), 64'({1'b1, 4'd5, 1'b0}));
`ifdef SCHED_PERF_EN
    check("perf_last", 64'(a_perf_last), 64'd20);
`endif
    @(negedge clk);
    check("cpl_cleared", 64'(a_cpl_valid), 64'd0);
`ifdef SCHED_PERF_EN
    check("perf_jobs", 64'(a_perf_jobs), 64'd1);
`endif
    drain();

    // Fill the queue behind a job stuck in the wrapper.
    tick(1);
    push_job(4'd0, 13'h100, 13'h101, 13'h102, 5, acc, k);
    wait_start(1'b0, s);
    tick(1);
    for (int i = 1; i <= 5; i++) begin
      push_job(TW'(i), AW'(16 * i), AW'(16 * i + 1), AW'(16 * i + 2), 1, acc, k);
      check($sformatf("fill_accept_%0d", i), 64'(acc), 64'(i <= 4));
    end
    check("fill_count_busy", 64'({a_queue_count, a_busy}), 64'({3'd4, 1'b1}));
    pulse_done();
    cmd_valid = 1'b1;
    cmd_tag   = 4'd5;
    cmd_w     = 13'h050;
    cmd_x     = 13'h051;
    cmd_o     = 13'h052;
    found     = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (a_cmd_ready === 1'b1) begin
        found = 1'b1;
        check("retry_after_pop", 64'({a_mm_start, a_queue_count}), 64'({1'b1, 3'd3}));
        issue_q.push_back({13'h050, 13'h051, 13'h052});
        cpl_q.push_back({4'd5, 1'b0});
      end
      tick(1);
    end
    cmd_valid = 1'b0;
    check("retry_accepted", 64'(found), 64'd1);
    tick(2);
    pulse_done();
    for (int j = 2; j <= 5; j++) begin
      wait_start(1'b0, s);
      tick(2);
      pulse_done();
    end
    drain();

    // Completion held back by cpl_ready.
    tick(1);
    push_job(4'd9, 13'h0a0, 13'h0b0, 13'h0c0, 5, acc, k);
    wait_start(1'b0, s);
    tick(1);
    push_job(4'd10, 13'h0d0, 13'h0e0, 13'h0f0, 5, acc, k);
    cpl_ready = 1'b0;
    tick(2);
    pulse_done();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("cpl_hold_%0d", i),
            64'({a_cpl_valid, a_cpl_tag, a_cpl_err, a_mm_start}),
            64'({1'b1, 4'd9, 1'b0, 1'b0}));
    end
    tick(1);
    p = cyc;
    cpl_ready = 1'b1;
    wait_start(1'b0, s);
    check("b2b_start", 64'(s), 64'(p + 3));
    tick(2);
    pulse_done();
    drain();

    // Timeout on the 16-cycle copy, then halt.
    mon_en = 1'b0;
    issue_q.delete();
    cpl_q.delete();
    do_reset(2);
    push_job(4'd3, 13'h010, 13'h020, 13'h030, 5, acc, k);
    wait_start(1'b1, s);
    tick(1);
    push_job(4'd4, 13'h011, 13'h021, 13'h031, 5, acc, k);
    do @(negedge clk); while (cyc < s + 15);
    check("to_not_yet", 64'(t_cpl_valid), 64'd0);
    @(negedge clk);
    check("to_cpl", 64'({t_cpl_valid, t_cpl_tag, t_cpl_err}), 64'({1'b1, 4'd3, 1'b1}));
    nstart = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (t_mm_start === 1'b1) nstart++;
    end
    check("halt_no_start", 64'(nstart), 64'd0);
    check("halt_state", 64'({t_queue_count, t_busy, t_cmd_ready, t_cpl_valid}),
          64'({3'd1, 1'b1, 1'b1, 1'b0}));
    tick(1);
    push_job(4'd11, 13'h012, 13'h022, 13'h032, 5, acc, k);
    check("halt_accepts", 64'(t_queue_count), 64'd2);

    // Done on the expiry cycle wins.
    do_reset(2);
    push_job(4'd6, 13'h013, 13'h023, 13'h033, 5, acc, k);
    wait_start(1'b1, s);
    repeat (15) @(posedge clk);
    #1;
    pulse_done();
    @(negedge clk);
    check("expiry_done", 64'({t_cpl_valid, t_cpl_tag, t_cpl_err}), 64'({1'b1, 4'd6, 1'b0}));
    tick(3);
    check("expiry_idle", 64'(t_busy), 64'd0);

    // Reset while a job is in flight.
    do_reset(2);
    push_job(4'd7, 13'h014, 13'h024, 13'h034, 5, acc, k);
    wait_start(1'b0, s);
    tick(1);
    push_job(4'd8, 13'h015, 13'h025, 13'h035, 5, acc, k);
    push_job(4'd9, 13'h016, 13'h026, 13'h036, 5, acc, k);
    check("pre_rst_count", 64'(a_queue_count), 64'd2);
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready_low", 64'(a_cmd_ready), 64'd0);
    tick(1);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_clear", 64'({a_queue_count, a_cpl_valid, a_busy, a_mm_start}), 64'd0);
    tick(1);
    pulse_done();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stray_done_%0d", i), 64'({a_cpl_valid, a_mm_start, a_busy}), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
